// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and helpers for the two-way cache controller
// Purpose: FSM state encoding, way identifiers and the victim-selection rule.
// Ports: none (package).
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } cache_state_t;

    typedef logic way_t;

    localparam way_t WAY_A = 1'b0;
    localparam way_t WAY_B = 1'b1;

    // Replacement choice on a miss: fill an empty way first (A before B),
    // and only evict by LRU when both ways hold live lines.
    function automatic way_t pickVictim(input logic [1:0] valid, input logic lru);
        way_t v;
        if (!valid[WAY_A]) begin
            v = WAY_A;
        end else if (!valid[WAY_B]) begin
            v = WAY_B;
        end else begin
            v = way_t'(lru);
        end
        return v;
    endfunction

endpackage

// File: rtl/cache_perf_counters.sv
// rtl/cache_perf_counters.sv - saturating hit/miss counters for the cache controller
// Purpose: count first-look hits and misses; each counter sticks at all-ones.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   incHit, incMiss   - one-cycle increment requests
//   hitCount          - CNT_W-bit hit total
//   missCount         - CNT_W-bit miss total
module cache_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             incHit,
    input  logic             incMiss,
    output logic [CNT_W-1:0] hitCount,
    output logic [CNT_W-1:0] missCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hitCount  <= '0;
            missCount <= '0;
        end else begin
            if (incHit && (hitCount != CNT_MAX)) begin
                hitCount <= hitCount + CNT_ONE;
            end
            if (incMiss && (missCount != CNT_MAX)) begin
                missCount <= missCount + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - control FSM for the two-way set-associative cache
// Purpose: sequences hit, clean-miss refill and dirty-miss writeback+refill,
// driving cache_datapath strobes from its hit/valid/dirty/LRU status.
// Optional feature macro: CACHE_PERF_CNT_EN (hit/miss counters; tied to 0 otherwise).
// Ports:
//   clk, rst                        - clock, asynchronous active-low reset
//   cpu_req, cpu_we, cpu_ack        - CPU handshake (ack is a one-cycle pulse)
//   isHit, hitWay, isValid,
//   isDirty, LRUout                 - datapath status at the current index
//   dataWriteEn, tagWriteEn,
//   setValid, writeValid,
//   setDirty, writeDirty,
//   LRU_load, LRU_datain,
//   fillSel, wbAddrSel              - datapath strobes and muxes (Mealy)
//   mem_read, mem_write, mem_ack    - line-wide memory port (requests are Moore)
//   hit_count, miss_count           - performance counters
module cache_controller
    import cache_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    output logic             cpu_ack,
    input  logic             isHit,
    input  logic             hitWay,
    input  logic [1:0]       isValid,
    input  logic [1:0]       isDirty,
    input  logic             LRUout,
    output logic [1:0]       dataWriteEn,
    output logic [1:0]       tagWriteEn,
    output logic [1:0]       setValid,
    output logic [1:0]       writeValid,
    output logic [1:0]       setDirty,
    output logic [1:0]       writeDirty,
    output logic             LRU_load,
    output logic             LRU_datain,
    output logic             fillSel,
    output logic             wbAddrSel,
    output logic             mem_read,
    output logic             mem_write,
    input  logic             mem_ack,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    cache_state_t state;
    way_t         victim;
    way_t         victimNext;
    logic         victimDirty;

    // Victim is chosen from the metadata visible in COMPARE and frozen, so the
    // fill lands in the same way even if the index status changes meanwhile.
    assign victimNext  = pickVictim(isValid, LRUout);
    assign victimDirty = isValid[victimNext] & isDirty[victimNext];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            victim <= WAY_A;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (isHit) begin
                        state <= IDLE;
                    end else begin
                        victim <= victimNext;
                        state  <= victimDirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        state <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_ack) begin
                        state <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory requests depend on state only, so an asserted reset removes
    // them in the same cycle.
    assign mem_read  = (state == ALLOCATE);
    assign mem_write = (state == WRITEBACK);

    always_comb begin
        cpu_ack     = 1'b0;
        dataWriteEn = 2'b00;
        tagWriteEn  = 2'b00;
        setValid    = 2'b00;
        writeValid  = 2'b00;
        setDirty    = 2'b00;
        writeDirty  = 2'b00;
        LRU_load    = 1'b0;
        LRU_datain  = 1'b0;
        fillSel     = 1'b0;
        wbAddrSel   = 1'b0;
        case (state)
            COMPARE: begin
                if (isHit) begin
                    cpu_ack    = 1'b1;
                    LRU_load   = 1'b1;
                    LRU_datain = ~hitWay;
                    // Store merge: CPU data into the hit way, line becomes dirty.
                    if (cpu_we) begin
                        dataWriteEn[hitWay] = 1'b1;
                        writeDirty[hitWay]  = 1'b1;
                        setDirty[hitWay]    = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                wbAddrSel = 1'b1;
            end
            ALLOCATE: begin
                fillSel = 1'b1;
                // Install the fetched line clean; a pending store merges on
                // the re-compare that follows.
                if (mem_ack) begin
                    dataWriteEn[victim] = 1'b1;
                    tagWriteEn[victim]  = 1'b1;
                    writeValid[victim]  = 1'b1;
                    setValid[victim]    = 1'b1;
                    writeDirty[victim]  = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    // Marks that the next COMPARE is the post-refill re-check, which must not
    // be counted as a hit.
    logic refilled;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refilled <= 1'b0;
        end else if ((state == COMPARE) && isHit) begin
            refilled <= 1'b0;
        end else if ((state == ALLOCATE) && mem_ack) begin
            refilled <= 1'b1;
        end
    end

    cache_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .incHit    ((state == COMPARE) && isHit && !refilled),
        .incMiss   ((state == COMPARE) && !isHit),
        .hitCount  (hit_count),
        .missCount (miss_count)
    );
`else
    assign hit_count  = {CNT_W{1'b0}};
    assign miss_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed self-checking bench for cache_controller
module tb_cache_controller;
    import cache_pkg::*;

`ifdef CACHE_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_ack;
    logic        isHit;
    logic        hitWay;
    logic [1:0]  isValid;
    logic [1:0]  isDirty;
    logic        LRUout;
    logic [1:0]  dataWriteEn;
    logic [1:0]  tagWriteEn;
    logic [1:0]  setValid;
    logic [1:0]  writeValid;
    logic [1:0]  setDirty;
    logic [1:0]  writeDirty;
    logic        LRU_load;
    logic        LRU_datain;
    logic        fillSel;
    logic        wbAddrSel;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks = 0;
    int errors = 0;
    int readCycles;

    logic [18:0] allOut;
    assign allOut = {cpu_ack, dataWriteEn, tagWriteEn, setValid, writeValid, setDirty,
                     writeDirty, LRU_load, LRU_datain, fillSel, wbAddrSel, mem_read, mem_write};

    cache_controller #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_ack     (cpu_ack),
        .isHit       (isHit),
        .hitWay      (hitWay),
        .isValid     (isValid),
        .isDirty     (isDirty),
        .LRUout      (LRUout),
        .dataWriteEn (dataWriteEn),
        .tagWriteEn  (tagWriteEn),
        .setValid    (setValid),
        .writeValid  (writeValid),
        .setDirty    (setDirty),
        .writeDirty  (writeDirty),
        .LRU_load    (LRU_load),
        .LRU_datain  (LRU_datain),
        .fillSel     (fillSel),
        .wbAddrSel   (wbAddrSel),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_ack     (mem_ack),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive point: just after the rising edge. Sample point: falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; isHit = 1'b0; hitWay = 1'b0;
        isValid = 2'b00; isDirty = 2'b00; LRUout = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        sample();
        check("rst_state", 64'(dut.state), 64'(IDLE));
        check("rst_outputs", 64'(allOut), 64'd0);
        check("rst_hit_count", 64'(hit_count), 64'd0);
        check("rst_miss_count", 64'(miss_count), 64'd0);
        tick();
        rst = 1'b1;

        // Load hit in way A: ack in cycle 1, LRU points at B, nothing else written.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0;
        sample();
        check("lh_c0_ack", 64'(cpu_ack), 64'd0);
        tick();
        isHit = 1'b1; hitWay = 1'b0; isValid = 2'b01;
        sample();
        check("lh_ack", 64'(cpu_ack), 64'd1);
        check("lh_lru_load", 64'(LRU_load), 64'd1);
        check("lh_lru_datain", 64'(LRU_datain), 64'd1);
        check("lh_no_writes", 64'({dataWriteEn, tagWriteEn, writeValid, setValid, writeDirty, setDirty}), 64'd0);
        tick();
        cpu_req = 1'b0; isHit = 1'b0;
        sample();
        check("lh_back_idle", 64'(dut.state), 64'(IDLE));
        check("lh_ack_pulse", 64'(cpu_ack), 64'd0);

        // Store hit in way B.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1;
        tick();
        isHit = 1'b1; hitWay = 1'b1; isValid = 2'b11;
        sample();
        check("sh_ack", 64'(cpu_ack), 64'd1);
        check("sh_dwe", 64'(dataWriteEn), 64'b10);
        check("sh_wdirty", 64'(writeDirty), 64'b10);
        check("sh_sdirty", 64'(setDirty), 64'b10);
        check("sh_lru_datain", 64'(LRU_datain), 64'd0);
        check("sh_fillsel", 64'(fillSel), 64'd0);
        tick();
        cpu_req = 1'b0; isHit = 1'b0; cpu_we = 1'b0;
        sample();
        check("sh_hit_count", 64'(hit_count), 64'(2 * PERF));

        // Clean miss: only A valid so B is the victim; ack arrives on the 5th ALLOCATE cycle.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0;
        tick();
        isHit = 1'b0; isValid = 2'b01; isDirty = 2'b00; LRUout = 1'b0;
        sample();
        check("cm_compare_ack", 64'(cpu_ack), 64'd0);
        check("cm_no_wb", 64'(mem_write), 64'd0);
        readCycles = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            mem_ack = (i == 4);
            sample();
            if (mem_read) readCycles++;
            check("cm_fillsel", 64'(fillSel), 64'd1);
            if (i == 4) begin
                check("cm_tagwe", 64'(tagWriteEn), 64'b10);
                check("cm_setvalid", 64'(setValid), 64'b10);
                check("cm_wvalid", 64'(writeValid), 64'b10);
                check("cm_dwe", 64'(dataWriteEn), 64'b10);
                check("cm_wdirty", 64'(writeDirty), 64'b10);
                check("cm_sdirty", 64'(setDirty), 64'b00);
            end else begin
                check("cm_tagwe_idle", 64'(tagWriteEn), 64'b00);
            end
        end
        check("cm_read_cycles", 64'(readCycles), 64'd5);
        tick();
        mem_ack = 1'b0; isHit = 1'b1; hitWay = 1'b1; isValid = 2'b11;
        sample();
        check("cm_recompare_ack", 64'(cpu_ack), 64'd1);
        check("cm_read_dropped", 64'(mem_read), 64'd0);
        tick();
        cpu_req = 1'b0; isHit = 1'b0;
        sample();
        check("cm_miss_count", 64'(miss_count), 64'(PERF));
        check("cm_hit_count", 64'(hit_count), 64'(2 * PERF));

        // Dirty miss with store: both valid, LRU = A, A dirty -> writeback then fill A.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1;
        tick();
        isHit = 1'b0; isValid = 2'b11; isDirty = 2'b01; LRUout = 1'b0;
        sample();
        check("dm_compare_ack", 64'(cpu_ack), 64'd0);
        tick();
        sample();
        check("dm_wb_state", 64'(dut.state), 64'(WRITEBACK));
        check("dm_wb_req", 64'({mem_write, wbAddrSel, mem_read}), 64'b110);
        tick();
        mem_ack = 1'b1;
        sample();
        check("dm_wb_held", 64'({mem_write, wbAddrSel}), 64'b11);
        tick();
        sample();
        check("dm_alloc_state", 64'(dut.state), 64'(ALLOCATE));
        check("dm_alloc_req", 64'({mem_read, mem_write, fillSel}), 64'b101);
        check("dm_fill_a", 64'({dataWriteEn, tagWriteEn, setValid, writeValid}), 64'b01010101);
        check("dm_fill_clean", 64'({writeDirty, setDirty}), 64'b0100);
        tick();
        mem_ack = 1'b0; isHit = 1'b1; hitWay = 1'b0;
        sample();
        check("dm_ack", 64'(cpu_ack), 64'd1);
        check("dm_merge", 64'({dataWriteEn, writeDirty, setDirty, fillSel}), 64'b0101010);
        check("dm_lru_datain", 64'(LRU_datain), 64'd1);
        tick();
        cpu_req = 1'b0; isHit = 1'b0; cpu_we = 1'b0;
        sample();
        check("dm_miss_count", 64'(miss_count), 64'(2 * PERF));
        check("dm_hit_count", 64'(hit_count), 64'(2 * PERF));

        // Stray memory ack while idle.
        tick();
        mem_ack = 1'b1;
        sample();
        check("stray_outputs", 64'(allOut), 64'd0);
        tick();
        mem_ack = 1'b0;
        sample();
        check("stray_state", 64'(dut.state), 64'(IDLE));

        // Reset asserted while ALLOCATE is pending.
        tick();
        cpu_req = 1'b1;
        tick();
        isHit = 1'b0; isValid = 2'b00; isDirty = 2'b00;
        tick();
        sample();
        check("rs_read_before", 64'(mem_read), 64'd1);
        check("rs_miss_count", 64'(miss_count), 64'(3 * PERF));
        rst = 1'b0;
        #1;
        check("rs_read_dropped", 64'(mem_read), 64'd0);
        check("rs_outputs", 64'(allOut), 64'd0);
        tick();
        cpu_req = 1'b0;
        tick();
        rst = 1'b1;
        sample();
        check("rs_state", 64'(dut.state), 64'(IDLE));
        check("rs_victim", 64'(dut.victim), 64'd0);
        check("rs_hit_count", 64'(hit_count), 64'd0);
        check("rs_miss_count_zero", 64'(miss_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
